// File: rtl/trace_pkg.sv
// Shared types for the retirement trace port.
// TRACE_TIMESTAMP_EN adds a 32-bit timestamp field to each record and a fifth trace word.
package trace_pkg;

  localparam int REC_XLEN      = 32;
  localparam int DROP_W        = 16;
  localparam int RD_W          = 5;
  localparam int TS_W          = 32;
  localparam int META_LOST_BIT = 31;
  localparam int META_WE_BIT   = 8;
  localparam int META_RD_LSB   = 0;

  typedef struct packed {
    logic [REC_XLEN-1:0] pc;
    logic [REC_XLEN-1:0] instr;
    logic [REC_XLEN-1:0] wdata;
    logic [RD_W-1:0]     rd;
    logic                we;
    logic                lost;
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]     ts;
`endif
  } trace_rec_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_W_PC    = 3'd1,
    S_W_INSTR = 3'd2,
    S_W_DATA  = 3'd3,
    S_W_META  = 3'd4,
    S_W_TS    = 3'd5
  } trace_state_e;

`ifdef TRACE_TIMESTAMP_EN
  localparam trace_state_e S_LAST = S_W_TS;
`else
  localparam trace_state_e S_LAST = S_W_META;
`endif

  function automatic logic [REC_XLEN-1:0] meta_word(input trace_rec_t rec);
    logic [REC_XLEN-1:0] w;
    w = '0;
    w[META_LOST_BIT]           = rec.lost;
    w[META_WE_BIT]             = rec.we;
    w[META_RD_LSB +: RD_W]     = rec.rd;
    return w;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace records. The pop-side output register doubles as the
// serializer's holding register, so a popped record stays put until the next pop.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  trace_rec_t i_push_rec,
  input  logic       i_pop,
  output trace_rec_t o_pop_rec,
  output logic       o_full,
  output logic       o_empty
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  trace_rec_t    r_mem [DEPTH];
  trace_rec_t    r_pop_rec;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full    = (r_count == FULL_COUNT);
  assign o_empty   = (r_count == '0);
  assign w_push    = i_push && !o_full;
  assign w_pop     = i_pop && !o_empty;
  assign o_pop_rec = r_pop_rec;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_rec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_pop_rec <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_pop_rec <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/retire_trace_port.sv
// Retirement trace producer: captures WB-stage retire events into a FIFO and streams
// each record word-serially over valid/ready. TRACE_TIMESTAMP_EN appends a cycle-count word.
module retire_trace_port
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int XLEN  = REC_XLEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              retire_valid,
  input  logic [XLEN-1:0]   retire_pc,
  input  logic [XLEN-1:0]   retire_instr,
  input  logic [XLEN-1:0]   retire_wdata,
  input  logic [4:0]        retire_rd,
  input  logic              retire_we,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [XLEN-1:0]   trace_data,
  output logic              trace_last,
  output logic              trace_ovf,
  output logic [DROP_W-1:0] drop_count
);

  trace_state_e      r_state;
  trace_state_e      w_state_next;
  trace_rec_t        w_push_rec;
  trace_rec_t        w_held;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_drop;
  logic              w_pop;
  logic              w_xfer;
  logic              w_is_last;
  logic              r_lost_pending;
  logic              r_ovf;
  logic [DROP_W-1:0] r_drop_count;

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
    end
  end
`endif

  // Full is taken from the registered count, so a same-cycle pop never rescues a push.
  assign w_push = retire_valid && !w_full;
  assign w_drop = retire_valid && w_full;

  always_comb begin
    w_push_rec       = '0;
    w_push_rec.pc    = retire_pc;
    w_push_rec.instr = retire_instr;
    w_push_rec.wdata = retire_wdata;
    w_push_rec.rd    = retire_rd;
    w_push_rec.we    = retire_we;
    w_push_rec.lost  = r_lost_pending;
`ifdef TRACE_TIMESTAMP_EN
    w_push_rec.ts    = r_ts;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lost_pending <= 1'b0;
      r_ovf          <= 1'b0;
      r_drop_count   <= '0;
    end else if (w_push) begin
      r_lost_pending <= 1'b0;
    end else if (w_drop) begin
      r_lost_pending <= 1'b1;
      r_ovf          <= 1'b1;
      if (r_drop_count != '1) begin
        r_drop_count <= r_drop_count + DROP_W'(1);
      end
    end
  end

  assign trace_ovf  = r_ovf;
  assign drop_count = r_drop_count;

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_push_rec (w_push_rec),
    .i_pop      (w_pop),
    .o_pop_rec  (w_held),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Every non-idle state presents a word, so a transfer is just ready outside IDLE.
  assign w_xfer    = (r_state != S_IDLE) && trace_ready;
  assign w_is_last = (r_state == S_LAST);
  assign w_pop     = ((r_state == S_IDLE) || (w_is_last && w_xfer)) && !w_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (!w_empty) w_state_next = S_W_PC;
      S_W_PC:    if (w_xfer)   w_state_next = S_W_INSTR;
      S_W_INSTR: if (w_xfer)   w_state_next = S_W_DATA;
      S_W_DATA:  if (w_xfer)   w_state_next = S_W_META;
`ifdef TRACE_TIMESTAMP_EN
      S_W_META:  if (w_xfer)   w_state_next = S_W_TS;
      S_W_TS:    if (w_xfer)   w_state_next = w_empty ? S_IDLE : S_W_PC;
`else
      S_W_META:  if (w_xfer)   w_state_next = w_empty ? S_IDLE : S_W_PC;
      S_W_TS:                  w_state_next = S_IDLE;
`endif
      default:                 w_state_next = S_IDLE;
    endcase
  end

  // Outputs depend only on registered state and the held record, so they stay stable under backpressure.
  always_comb begin
    trace_valid = 1'b0;
    trace_data  = '0;
    trace_last  = w_is_last;
    case (r_state)
      S_W_PC: begin
        trace_valid = 1'b1;
        trace_data  = w_held.pc;
      end
      S_W_INSTR: begin
        trace_valid = 1'b1;
        trace_data  = w_held.instr;
      end
      S_W_DATA: begin
        trace_valid = 1'b1;
        trace_data  = w_held.wdata;
      end
      S_W_META: begin
        trace_valid = 1'b1;
        trace_data  = meta_word(w_held);
      end
`ifdef TRACE_TIMESTAMP_EN
      S_W_TS: begin
        trace_valid = 1'b1;
        trace_data  = w_held.ts;
      end
`endif
      default: begin
        trace_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_retire_trace_port.sv
// Bench for retire_trace_port: a queue-based record model checked every cycle plus directed
// scenarios with hand-computed words. Define TRACE_TIMESTAMP_EN for the 5-word record variant.
module tb_retire_trace_port;

  localparam int DEPTH = 16;
  localparam int XLEN  = 32;
`ifdef TRACE_TIMESTAMP_EN
  localparam int RW = 5;
`else
  localparam int RW = 4;
`endif

  logic            clk          = 1'b0;
  logic            reset        = 1'b1;
  logic            retire_valid = 1'b0;
  logic [XLEN-1:0] retire_pc    = '0;
  logic [XLEN-1:0] retire_instr = '0;
  logic [XLEN-1:0] retire_wdata = '0;
  logic [4:0]      retire_rd    = '0;
  logic            retire_we    = 1'b0;
  logic            trace_ready  = 1'b0;
  logic            trace_valid;
  logic [XLEN-1:0] trace_data;
  logic            trace_last;
  logic            trace_ovf;
  logic [15:0]     drop_count;

  always #5 clk = ~clk;

  retire_trace_port #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk          (clk),
    .reset        (reset),
    .retire_valid (retire_valid),
    .retire_pc    (retire_pc),
    .retire_instr (retire_instr),
    .retire_wdata (retire_wdata),
    .retire_rd    (retire_rd),
    .retire_we    (retire_we),
    .trace_valid  (trace_valid),
    .trace_ready  (trace_ready),
    .trace_data   (trace_data),
    .trace_last   (trace_last),
    .trace_ovf    (trace_ovf),
    .drop_count   (drop_count)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        we;
    logic        lost;
    logic [31:0] ts;
  } mrec_t;

  // Model: records waiting in the buffer, and the words of the record currently being sent.
  mrec_t       pend_q[$];
  logic [31:0] cur_q[$];
  int          m_drop = 0;
  logic        m_ovf  = 1'b0;
  logic        m_lost = 1'b0;
  logic [31:0] m_ts   = '0;

  logic [31:0] obs_data[$];
  logic        obs_last[$];
  int          obs_cyc[$];
  int          cyc_n    = 0;
  int          checks   = 0;
  int          failures = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  function automatic void load_cur(input mrec_t r);
    cur_q.delete();
    cur_q.push_back(r.pc);
    cur_q.push_back(r.instr);
    cur_q.push_back(r.wdata);
    cur_q.push_back({r.lost, 22'b0, r.we, 3'b0, r.rd});
`ifdef TRACE_TIMESTAMP_EN
    cur_q.push_back(r.ts);
`endif
  endfunction

  task automatic model_step();
    bit    full;
    mrec_t r;
    if (reset) begin
      pend_q.delete();
      cur_q.delete();
      m_drop = 0;
      m_ovf  = 1'b0;
      m_lost = 1'b0;
      m_ts   = '0;
    end else begin
      full = (pend_q.size() == DEPTH);
      if (cur_q.size() == 0) begin
        if (pend_q.size() > 0) begin
          r = pend_q.pop_front();
          load_cur(r);
        end
      end else if (trace_ready) begin
        cur_q.delete(0);
        if (cur_q.size() == 0 && pend_q.size() > 0) begin
          r = pend_q.pop_front();
          load_cur(r);
        end
      end
      if (retire_valid) begin
        if (full) begin
          if (m_drop < 65535) m_drop++;
          m_ovf  = 1'b1;
          m_lost = 1'b1;
        end else begin
          r.pc = retire_pc; r.instr = retire_instr; r.wdata = retire_wdata;
          r.rd = retire_rd; r.we = retire_we; r.lost = m_lost; r.ts = m_ts;
          pend_q.push_back(r);
          m_lost = 1'b0;
        end
      end
      m_ts = m_ts + 32'd1;
    end
  endtask

  // Per-cycle compare against the model, plus a log of every transferred word.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk1("valid", trace_valid, cur_q.size() != 0);
      if (trace_valid && cur_q.size() != 0) begin
        chk("data", trace_data, cur_q[0]);
        chk1("last", trace_last, cur_q.size() == 1);
      end
      chk1("ovf", trace_ovf, m_ovf);
      chk("drop_count", 32'(drop_count), 32'(m_drop));
      if (trace_valid && trace_ready) begin
        obs_data.push_back(trace_data);
        obs_last.push_back(trace_last);
        obs_cyc.push_back(cyc_n);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_retire(input logic [31:0] pc, input logic [31:0] instr,
                              input logic [31:0] wdata, input logic [4:0] rd, input logic we);
    retire_valid = 1'b1;
    retire_pc    = pc;
    retire_instr = instr;
    retire_wdata = wdata;
    retire_rd    = rd;
    retire_we    = we;
  endtask

  task automatic wait_obs(input string nm, input int target, input int budget);
    int k;
    k = 0;
    while (obs_data.size() < target && k < budget) begin
      tick();
      k++;
    end
    chk1(nm, obs_data.size() >= target, 1'b1);
  endtask

  task automatic chk_rec(input string nm, input int b, input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3);
    chk1({nm, "_present"}, obs_data.size() >= b + RW, 1'b1);
    if (obs_data.size() >= b + RW) begin
      chk({nm, "_pc"},    obs_data[b],     w0);
      chk({nm, "_instr"}, obs_data[b + 1], w1);
      chk({nm, "_wdata"}, obs_data[b + 2], w2);
      chk({nm, "_meta"},  obs_data[b + 3], w3);
      chk1({nm, "_last_meta"}, obs_last[b + 3], RW == 4);
      chk1({nm, "_last_end"},  obs_last[b + RW - 1], 1'b1);
    end
  endtask

  initial begin
    int n;
    int b;
    int b2;

    repeat (3) tick();
    chk1("rst_valid", trace_valid, 1'b0);
    chk("rst_data", trace_data, 32'h0);
    chk1("rst_last", trace_last, 1'b0);
    chk1("rst_ovf", trace_ovf, 1'b0);
    chk("rst_drop", 32'(drop_count), 32'h0);
    reset       = 1'b0;
    trace_ready = 1'b1;
    tick();

    // Single retire: words in cycles N+2..N+5.
    b = obs_data.size(); n = cyc_n;
    drive_retire(32'h10, 32'h00500093, 32'h5, 5'd1, 1'b1);
    tick(); retire_valid = 1'b0;
    wait_obs("t1_done", b + RW, 20);
    chk_rec("t1", b, 32'h10, 32'h00500093, 32'h5, 32'h00000101);
    if (obs_cyc.size() >= b + 4) begin
      chk("t1_first_cycle", 32'(obs_cyc[b]), 32'(n + 2));
      chk("t1_meta_cycle", 32'(obs_cyc[b + 3]), 32'(n + 5));
    end
    repeat (2) tick();

    // Backpressure during the instruction word.
    b = obs_data.size(); n = cyc_n;
    drive_retire(32'h20, 32'h00500093, 32'h7, 5'd2, 1'b1);
    tick(); retire_valid = 1'b0;
    tick(); tick();
    trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_hold", trace_data, 32'h00500093);
      chk1("t2_hold_valid", trace_valid, 1'b1);
      tick();
    end
    trace_ready = 1'b1;
    wait_obs("t2_done", b + RW, 20);
    chk_rec("t2", b, 32'h20, 32'h00500093, 32'h7, 32'h00000102);
    if (obs_cyc.size() >= b + 2) begin
      chk("t2_instr_cycle", 32'(obs_cyc[b + 1]), 32'(n + 6));
    end
    repeat (2) tick();

    // Overflow: one record held in the serializer, then 18 retires into a 16-deep buffer.
    trace_ready = 1'b0;
    b = obs_data.size();
    drive_retire(32'h100, 32'h1, 32'h1, 5'd1, 1'b0);
    tick(); retire_valid = 1'b0;
    tick(); tick();
    chk1("t3_held", trace_valid, 1'b1);
    for (int i = 0; i < 18; i++) begin
      drive_retire(32'h200 + 32'(4 * i), 32'(i), 32'(i + 1), i[4:0], i[0]);
      tick();
    end
    retire_valid = 1'b0;
    tick();
    chk("t3_drop", 32'(drop_count), 32'd2);
    chk1("t3_ovf", trace_ovf, 1'b1);
    trace_ready = 1'b1;
    wait_obs("t3_drain", b + 17 * RW, 17 * RW + 20);
    if (obs_data.size() >= b + 17 * RW) begin
      chk("t3_rec1_pc", obs_data[b + RW], 32'h200);
      chk("t3_rec16_pc", obs_data[b + 16 * RW], 32'h23C);
      chk("t3_rec16_meta", obs_data[b + 16 * RW + 3], 32'h0000010F);
    end
    repeat (2) tick();
    b2 = obs_data.size();
    drive_retire(32'h300, 32'h13, 32'h0, 5'd3, 1'b1);
    tick();
    drive_retire(32'h304, 32'h13, 32'h0, 5'd4, 1'b0);
    tick(); retire_valid = 1'b0;
    wait_obs("t3_after", b2 + 2 * RW, 30);
    if (obs_data.size() >= b2 + 2 * RW) begin
      chk("t3_next_pc", obs_data[b2], 32'h300);
      chk("t3_next_meta", obs_data[b2 + 3], 32'h80000103);
      chk("t3_after_pc", obs_data[b2 + RW], 32'h304);
      chk("t3_after_meta", obs_data[b2 + RW + 3], 32'h00000004);
    end
    repeat (2) tick();

    // Back-to-back records with ready held high.
    b = obs_data.size(); n = cyc_n;
    drive_retire(32'h400, 32'hA, 32'hB, 5'd5, 1'b1);
    tick();
    drive_retire(32'h500, 32'hC, 32'hD, 5'd6, 1'b0);
    tick(); retire_valid = 1'b0;
    wait_obs("t4_done", b + 2 * RW, 30);
    if (obs_cyc.size() >= b + 2 * RW) begin
      for (int i = 0; i < 2 * RW; i++) begin
        chk("t4_cycle", 32'(obs_cyc[b + i]), 32'(n + 2 + i));
      end
    end
    chk_rec("t4_a", b, 32'h400, 32'hA, 32'hB, 32'h00000105);
    chk_rec("t4_b", b + RW, 32'h500, 32'hC, 32'hD, 32'h00000006);
    repeat (2) tick();

    // Reset in the middle of a record.
    drive_retire(32'h700, 32'h1, 32'h2, 5'd7, 1'b1);
    tick(); retire_valid = 1'b0;
    tick(); tick(); tick();
    chk("t5_in_wdata", trace_data, 32'h2);
    reset = 1'b1;
    tick();
    chk1("t5_valid", trace_valid, 1'b0);
    chk("t5_drop", 32'(drop_count), 32'h0);
    chk1("t5_ovf", trace_ovf, 1'b0);
    reset = 1'b0;
    tick(); tick();
    b = obs_data.size(); n = cyc_n;
    drive_retire(32'h600, 32'h00100113, 32'h1, 5'd2, 1'b1);
    tick(); retire_valid = 1'b0;
    wait_obs("t5_done", b + RW, 20);
    chk_rec("t5_clean", b, 32'h600, 32'h00100113, 32'h1, 32'h00000102);
    if (obs_cyc.size() >= b + 1) begin
      chk("t5_first_cycle", 32'(obs_cyc[b]), 32'(n + 2));
    end
    repeat (2) tick();

`ifdef TRACE_TIMESTAMP_EN
    // Timestamp: retire while the cycle counter reads 20.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (20) tick();
    b = obs_data.size();
    drive_retire(32'h800, 32'h13, 32'h0, 5'd0, 1'b0);
    tick(); retire_valid = 1'b0;
    wait_obs("t6_done", b + 5, 20);
    if (obs_data.size() >= b + 5) begin
      chk("t6_ts", obs_data[b + 4], 32'h00000014);
      chk1("t6_last_ts", obs_last[b + 4], 1'b1);
      chk1("t6_last_meta", obs_last[b + 3], 1'b0);
    end
    repeat (2) tick();
`endif

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
